// File: rtl/jtag_shift_ctrl.sv
// JTAG master sequencer: turns TAP-level commands (reset, IR/DR shift, idle
// clocks) into TCK/TMS/TDI waveforms and returns the captured TDO bits.
module jtag_shift_ctrl #(
  parameter int unsigned ClkDiv   = 2,
  parameter int unsigned MaxLen   = 64,
  parameter int unsigned LenWidth = $clog2(MaxLen + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [1:0]          cmd_op_i,
  input  logic [LenWidth-1:0] cmd_len_i,
  input  logic [MaxLen-1:0]   cmd_data_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [MaxLen-1:0]   rsp_data_o,
  output logic                busy_o,
  output logic                jtag_tck_o,
  output logic                jtag_trst_no,
  output logic                jtag_tms_o,
  output logic                jtag_tdi_o,
  input  logic                jtag_tdo_i
);

  localparam int unsigned DivW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
  localparam int unsigned IdxW = (MaxLen > 1) ? $clog2(MaxLen) : 1;

  localparam logic [1:0] OpReset = 2'd0;
  localparam logic [1:0] OpIr    = 2'd1;
  localparam logic [1:0] OpDr    = 2'd2;
  localparam logic [1:0] OpIdle  = 2'd3;

  typedef enum logic [2:0] {StIdle, StPre, StShift, StPost, StResp} state_e;

  // Number of TCK cycles spent in PRE to walk from Run-Test/Idle to the shift state
  function automatic logic [LenWidth-1:0] f_pre_len(input logic [1:0] op);
    logic [LenWidth-1:0] n;
    n = '0;
    case (op)
      OpReset: n = LenWidth'(6);
      OpIr:    n = LenWidth'(4);
      OpDr:    n = LenWidth'(3);
      default: n = '0;
    endcase
    return n;
  endfunction

  // TMS level for a given TCK cycle of a command
  function automatic logic f_tms(input logic [1:0] op, input logic [LenWidth-1:0] len,
                                 input state_e st, input logic [LenWidth-1:0] idx);
    logic t;
    t = 1'b0;
    case (st)
      StPre: begin
        case (op)
          OpReset: t = (idx < LenWidth'(5));
          OpIr:    t = (idx < LenWidth'(2));
          OpDr:    t = (idx == '0);
          default: t = 1'b0;
        endcase
      end
      StShift: t = (op != OpIdle) && (idx == len - LenWidth'(1));
      StPost:  t = (idx == '0);
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  // TDI level for a given TCK cycle; only data shifts carry payload
  function automatic logic f_tdi(input logic [1:0] op, input logic [MaxLen-1:0] data,
                                 input state_e st, input logic [LenWidth-1:0] idx);
    return (st == StShift) && (op != OpIdle) && data[IdxW'(idx)];
  endfunction

  state_e                r_state, w_state_nxt;
  logic [1:0]            r_op;
  logic [LenWidth-1:0]   r_len, r_idx, w_idx_nxt, w_len_sat, w_seg_len, w_idx_inc;
  logic [MaxLen-1:0]     r_data, r_rsp_data, w_rsp_data_nxt;
  logic [DivW-1:0]       r_div, w_div_nxt;
  logic                  r_fin, w_fin_nxt;
  logic                  r_tck, r_tms, r_tdi, r_trst_n, r_cmd_ready, r_rsp_valid, r_busy;
  logic                  w_tck_nxt, w_tms_nxt, w_tdi_nxt;
  logic                  w_accept, w_active, w_tick, w_rise, w_fall;

  assign w_accept  = cmd_valid_i & r_cmd_ready;
  assign w_len_sat = (cmd_len_i > LenWidth'(MaxLen)) ? LenWidth'(MaxLen) : cmd_len_i;
  assign w_active  = ((r_state == StPre) || (r_state == StShift) || (r_state == StPost)) && !r_fin;
  assign w_tick    = (r_div == DivW'(ClkDiv - 1));
  assign w_rise    = w_active & w_tick & ~r_tck;
  assign w_fall    = w_active & w_tick & r_tck;
  assign w_idx_inc = r_idx + LenWidth'(1);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= StIdle;
    else         r_state <= w_state_nxt;
  end

  // Next-state: segment sequencing on TCK falling edges
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_fin_nxt   = r_fin;
    w_seg_len   = '0;
    case (r_state)
      StPre:   w_seg_len = f_pre_len(r_op);
      StShift: w_seg_len = r_len;
      StPost:  w_seg_len = LenWidth'(2);
      default: w_seg_len = '0;
    endcase
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_idx_nxt = '0;
          if (cmd_op_i == OpReset)     w_state_nxt = StPre;
          else if (w_len_sat == '0)    w_state_nxt = StResp;
          else if (cmd_op_i == OpIdle) w_state_nxt = StShift;
          else                         w_state_nxt = StPre;
        end
      end
      StPre, StShift, StPost: begin
        if (r_fin) begin
          w_state_nxt = StResp;
          w_fin_nxt   = 1'b0;
        end else if (w_fall) begin
          if (w_idx_inc < w_seg_len) begin
            w_idx_nxt = w_idx_inc;
          end else begin
            w_idx_nxt = '0;
            case (r_state)
              StPre: begin
                if (r_op == OpReset) w_fin_nxt = 1'b1;
                else                 w_state_nxt = StShift;
              end
              StShift: begin
                if (r_op == OpIdle) w_fin_nxt = 1'b1;
                else                w_state_nxt = StPost;
              end
              default: w_fin_nxt = 1'b1;
            endcase
          end
        end
      end
      StResp:  if (rsp_ready_i) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Output next values: TCK divider, TMS/TDI drive, TDO capture, handshakes
  always_comb begin
    w_tck_nxt      = r_tck;
    w_tms_nxt      = r_tms;
    w_tdi_nxt      = r_tdi;
    w_div_nxt      = '0;
    w_rsp_data_nxt = r_rsp_data;
    if (w_active) w_div_nxt = w_tick ? '0 : r_div + DivW'(1);
    if (w_rise) w_tck_nxt = 1'b1;
    if (w_fall) w_tck_nxt = 1'b0;
    if (w_accept) begin
      w_tms_nxt      = f_tms(cmd_op_i, w_len_sat, w_state_nxt, '0);
      w_tdi_nxt      = f_tdi(cmd_op_i, cmd_data_i, w_state_nxt, '0);
      w_rsp_data_nxt = '0;
    end else if (w_fall) begin
      w_tms_nxt = !w_fin_nxt && f_tms(r_op, r_len, w_state_nxt, w_idx_nxt);
      w_tdi_nxt = !w_fin_nxt && f_tdi(r_op, r_data, w_state_nxt, w_idx_nxt);
    end
    if (w_rise && (r_state == StShift) && (r_op != OpIdle)) begin
      w_rsp_data_nxt[IdxW'(r_idx)] = jtag_tdo_i;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_op        <= '0;
      r_len       <= '0;
      r_data      <= '0;
      r_idx       <= '0;
      r_fin       <= 1'b0;
      r_div       <= '0;
      r_tck       <= 1'b0;
      r_tms       <= 1'b0;
      r_tdi       <= 1'b0;
      r_trst_n    <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_busy      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op   <= cmd_op_i;
        r_len  <= w_len_sat;
        r_data <= cmd_data_i;
      end
      r_idx       <= w_idx_nxt;
      r_fin       <= w_fin_nxt;
      r_div       <= w_div_nxt;
      r_tck       <= w_tck_nxt;
      r_tms       <= w_tms_nxt;
      r_tdi       <= w_tdi_nxt;
      r_trst_n    <= 1'b1;
      r_cmd_ready <= (w_state_nxt == StIdle);
      r_rsp_valid <= (w_state_nxt == StResp);
      r_rsp_data  <= w_rsp_data_nxt;
      r_busy      <= (w_state_nxt != StIdle);
    end
  end

  assign cmd_ready_o  = r_cmd_ready;
  assign rsp_valid_o  = r_rsp_valid;
  assign rsp_data_o   = r_rsp_data;
  assign busy_o       = r_busy;
  assign jtag_tck_o   = r_tck;
  assign jtag_trst_no = r_trst_n;
  assign jtag_tms_o   = r_tms;
  assign jtag_tdi_o   = r_tdi;

endmodule

// File: tb/tb_jtag_shift_ctrl.sv
// Bench for jtag_shift_ctrl: directed commands, scoreboard on the response
// channel, TCK-edge recorder checked against hand-written TMS/TDI sequences.
module tb_jtag_shift_ctrl;

  localparam int ClkDiv = 2;
  localparam int MaxLen = 64;
  localparam int LenW   = 7;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [1:0]      cmd_op = '0;
  logic [LenW-1:0] cmd_len = '0;
  logic [63:0]     cmd_data = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [63:0]     rsp_data;
  logic            busy, tck, trst_n, tms, tdi, tdo;

  always #5 clk = ~clk;

  jtag_shift_ctrl #(.ClkDiv(ClkDiv), .MaxLen(MaxLen)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_len_i(cmd_len), .cmd_data_i(cmd_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .busy_o(busy), .jtag_tck_o(tck), .jtag_trst_no(trst_n), .jtag_tms_o(tms),
    .jtag_tdi_o(tdi), .jtag_tdo_i(tdo)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // TCK recorder: TMS/TDI seen at every rising edge, plus its clk cycle
  int   cyc = 0;
  int   rise_total = 0;
  logic tms_log[$];
  logic tdi_log[$];
  int   rise_time[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge tck) begin
    tms_log.push_back(tms);
    tdi_log.push_back(tdi);
    rise_time.push_back(cyc);
    rise_total = rise_total + 1;
  end

  // TAP stand-in: presents tdo_vec bit k during the k-th shift TCK cycle
  int          base_rise = 0;
  int          tb_pre = 0;
  logic [63:0] tdo_vec = '0;
  int          tdo_idx;
  assign tdo_idx = rise_total - base_rise - tb_pre;
  assign tdo = (tdo_idx >= 0 && tdo_idx < 64) ? tdo_vec[tdo_idx[5:0]] : 1'b0;

  // Scoreboard monitor: pops an expectation on every response handshake
  logic [63:0] exp_q[$];
  string       name_q[$];
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", 64'(1), 64'(0));
      else chk({name_q.pop_front(), "_rsp_data"}, rsp_data, exp_q.pop_front());
    end
  end

  task automatic issue(input logic [1:0] op, input logic [LenW-1:0] len, input logic [63:0] data,
                       input logic [63:0] tv, input logic [63:0] exp, input string name,
                       input bit expect_rsp);
    int w;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) chk({name, "_ready_timeout"}, 64'(0), 64'(1));
    tdo_vec   = tv;
    tb_pre    = (op == 2'd1) ? 4 : (op == 2'd2) ? 3 : 0;
    base_rise = rise_total;
    cmd_op    = op;
    cmd_len   = len;
    cmd_data  = data;
    cmd_valid = 1'b1;
    if (expect_rsp) begin
      exp_q.push_back(exp);
      name_q.push_back(name);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = ~op;
    cmd_len   = '1;
    cmd_data  = ~data;
  endtask

  task automatic wait_rsp(input string name);
    bit seen;
    seen = 1'b0;
    for (int w = 0; w < 2000 && !seen; w++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) seen = 1'b1;
    end
    if (!seen) chk({name, "_rsp_timeout"}, 64'(0), 64'(1));
    @(posedge clk);
    #1;
  endtask

  // Expected TMS/TDI per TCK cycle, written out from the TAP walk for each op
  task automatic check_seq(input string name, input logic [1:0] op, input int len,
                           input logic [63:0] data);
    logic       et[$];
    logic       ed[$];
    logic [5:0] pat;
    int         plen, l, mism;
    l = (len > 64) ? 64 : len;
    pat = 6'b011111; plen = 6;
    if (op == 2'd1) begin pat = 6'b000011; plen = 4; end
    if (op == 2'd2) begin pat = 6'b000001; plen = 3; end
    if (op == 2'd3) plen = 0;
    if (op == 2'd0 || l > 0) begin
      for (int i = 0; i < plen; i++) begin et.push_back(pat[i]); ed.push_back(1'b0); end
      if (op == 2'd1 || op == 2'd2) begin
        for (int i = 0; i < l; i++) begin et.push_back(i == l - 1); ed.push_back(data[i]); end
        et.push_back(1'b1); ed.push_back(1'b0);
        et.push_back(1'b0); ed.push_back(1'b0);
      end
      if (op == 2'd3) begin
        for (int i = 0; i < l; i++) begin et.push_back(1'b0); ed.push_back(1'b0); end
      end
    end
    chk({name, "_tck_count"}, 64'(rise_total - base_rise), 64'(et.size()));
    mism = 0;
    for (int i = 0; i < et.size(); i++) begin
      if (base_rise + i >= tms_log.size()) mism++;
      else if (tms_log[base_rise + i] !== et[i] || tdi_log[base_rise + i] !== ed[i]) mism++;
    end
    chk({name, "_tms_tdi_mismatches"}, 64'(mism), 64'(0));
  endtask

  // Stimulus
  initial begin
    logic [63:0] held;
    int          bad, w;

    repeat (3) @(negedge clk);
    chk("reset_ctrl_outputs", 64'({tck, tms, tdi, trst_n, cmd_ready, rsp_valid, busy}), 64'(0));
    chk("reset_rsp_data", rsp_data, 64'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_trst_ready", 64'({trst_n, cmd_ready}), 64'(2'b11));

    // TAP reset command
    issue(2'd0, 7'd0, 64'h0, 64'h0, 64'h0, "reset_cmd", 1'b1);
    wait_rsp("reset_cmd");
    check_seq("reset_cmd", 2'd0, 0, 64'h0);
    bad = 0;
    for (int i = 1; i < 6; i++)
      if (rise_time[base_rise + i] - rise_time[base_rise + i - 1] != 2 * ClkDiv) bad++;
    chk("reset_cmd_tck_spacing", 64'(bad), 64'(0));
    chk("reset_cmd_ready_back", 64'(cmd_ready), 64'(1));

    // IR shift
    issue(2'd1, 7'd5, 64'h01, 64'h15, 64'h15, "ir5", 1'b1);
    wait_rsp("ir5");
    check_seq("ir5", 2'd1, 5, 64'h01);

    // DR IDCODE, upper TDO bits beyond len must not leak into the response
    issue(2'd2, 7'd32, 64'h0, {32'hFFFF_FFFF, 32'h1C5E_5DB3}, 64'h0000_0000_1C5E_5DB3, "dr32", 1'b1);
    wait_rsp("dr32");
    check_seq("dr32", 2'd2, 32, 64'h0);

    // Response backpressure with a competing command offered
    rsp_ready = 1'b0;
    issue(2'd1, 7'd3, 64'h5, 64'h6, 64'h6, "bp_ir3", 1'b1);
    w = 0;
    while (!rsp_valid && w < 500) begin @(negedge clk); w++; end
    if (!rsp_valid) chk("bp_rsp_timeout", 64'(0), 64'(1));
    held      = rsp_data;
    base_rise = rise_total;
    tb_pre    = 0;
    cmd_op    = 2'd3;
    cmd_len   = 7'd3;
    cmd_data  = 64'h0;
    cmd_valid = 1'b1;
    exp_q.push_back(64'h0);
    name_q.push_back("bp_idle3");
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== held || cmd_ready) bad++;
    end
    chk("bp_hold_violations", 64'(bad), 64'(0));
    chk("bp_no_tck_while_pending", 64'(rise_total - base_rise), 64'(0));
    rsp_ready = 1'b1;
    w = 0;
    while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
    if (!cmd_ready) chk("bp_accept_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_rsp("bp_idle3");
    check_seq("bp_idle3", 2'd3, 3, 64'h0);

    // Zero-length DR: response on the very next cycle, no TCK
    issue(2'd2, 7'd0, 64'hFF, 64'hFF, 64'h0, "dr0", 1'b1);
    chk("dr0_rsp_next_cycle", 64'(rsp_valid), 64'(1));
    wait_rsp("dr0");
    check_seq("dr0", 2'd2, 0, 64'h0);

    // Over-length DR saturates to 64 bits
    issue(2'd2, 7'd100, 64'hA5A5_0F0F_1234_5678, 64'hDEAD_BEEF_CAFE_F00D,
          64'hDEAD_BEEF_CAFE_F00D, "dr100", 1'b1);
    wait_rsp("dr100");
    check_seq("dr100", 2'd2, 100, 64'hA5A5_0F0F_1234_5678);

    // Idle clocks
    issue(2'd3, 7'd7, 64'hFFFF, 64'hFFFF, 64'h0, "idle7", 1'b1);
    wait_rsp("idle7");
    check_seq("idle7", 2'd3, 7, 64'h0);

    // Asynchronous reset during shift bit 10 of a DR scan
    issue(2'd2, 7'd32, 64'h0, 64'h1C5E_5DB3, 64'h0, "dr_abort", 1'b0);
    w = 0;
    while (rise_total - base_rise < 3 + 11 && w < 500) begin @(negedge clk); w++; end
    if (rise_total - base_rise < 3 + 11) chk("abort_reach_timeout", 64'(0), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_ctrl_outputs", 64'({tck, tms, tdi, trst_n, cmd_ready, rsp_valid, busy}), 64'(0));
    chk("abort_rsp_data", rsp_data, 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_release_trst_ready", 64'({trst_n, cmd_ready}), 64'(2'b11));
    issue(2'd0, 7'd0, 64'h0, 64'h0, 64'h0, "reset_after_abort", 1'b1);
    wait_rsp("reset_after_abort");
    check_seq("reset_after_abort", 2'd0, 0, 64'h0);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

endmodule
